// File: rtl/spi_pkg.sv
// rtl/spi_pkg.sv - shared SPI packet defaults and FSM state encoding
//
// Purpose : packet geometry defaults and the state enum used by both the
//           SPI master and the SPI slave, plus helpers that map a state to
//           the pin levels it drives.
// Ports   : none (package)
package spi_pkg;

  localparam int SPI_PKTSZ   = 16;
  localparam int SPI_HEADER  = 8;
  localparam int SPI_PAYLOAD = 8;
  localparam int SPI_ADDRSZ  = 7;

  typedef enum logic [2:0] {
    ST_IDLE,
    ST_SETUP,
    ST_LOW,
    ST_HIGH,
    ST_HOLD,
    ST_GAP
  } spi_state_e;

  // Slave select is asserted for the whole framed part of a packet.
  function automatic logic ssb_active(input spi_state_e s);
    return (s == ST_SETUP) || (s == ST_LOW) || (s == ST_HIGH) || (s == ST_HOLD);
  endfunction

  // MOSI carries packet bits only while SCLK edges are still to come.
  function automatic logic mosi_active(input spi_state_e s);
    return (s == ST_SETUP) || (s == ST_LOW) || (s == ST_HIGH);
  endfunction

endpackage

// File: rtl/sync_2ff.sv
// rtl/sync_2ff.sv - two-flop synchronizer for a single asynchronous input
//
// Purpose : bring an asynchronous level into the clk domain.
// Ports   : clk      in  system clock
//           reset_n  in  asynchronous active-low reset
//           d_i      in  asynchronous input
//           q_o      out synchronized output (two clk cycles of latency)
module sync_2ff (
  input  logic clk,
  input  logic reset_n,
  input  logic d_i,
  output logic q_o
);

  logic meta_q;
  logic sync_q;

  always_ff @(posedge clk or negedge reset_n) begin
    if (!reset_n) begin
      meta_q <= 1'b0;
      sync_q <= 1'b0;
    end else begin
      meta_q <= d_i;
      sync_q <= meta_q;
    end
  end

  assign q_o = sync_q;

endmodule

// File: rtl/spi_master.sv
// rtl/spi_master.sv - SPI master issuing {rw, addr, data} register packets
//
// Purpose : shifts out a PKTSZ-bit packet {rw, addr, wdata} MSB first and,
//           on reads, captures PAYLOAD bits from MISO after the header.
//           Every phase (SETUP, LOW, HIGH, HOLD, GAP) lasts CLKDIV cycles.
// Ports   : clk          in  system clock
//           reset_n      in  asynchronous active-low reset
//           start        in  transaction request, honoured only in IDLE
//           rw           in  0 = write, 1 = read
//           addr         in  slave register address
//           wdata        in  write payload
//           busy         out transaction in progress (through GAP)
//           done         out one-cycle pulse as SSB rises
//           rdata        out read payload, updated on read completion only
//           rdata_valid  out one-cycle pulse with done on reads
//           SCLK         out SPI clock, idle low
//           SSB          out slave select, active low
//           MOSI         out serial data to slave
//           MISO         in  serial data from slave (asynchronous)
module spi_master
  import spi_pkg::*;
#(
  parameter int PKTSZ   = SPI_PKTSZ,
  parameter int HEADER  = SPI_HEADER,
  parameter int PAYLOAD = SPI_PAYLOAD,
  parameter int ADDRSZ  = SPI_ADDRSZ,
  parameter int CLKDIV  = 8
) (
  input  logic               clk,
  input  logic               reset_n,
  input  logic               start,
  input  logic               rw,
  input  logic [ADDRSZ-1:0]  addr,
  input  logic [PAYLOAD-1:0] wdata,
  output logic               busy,
  output logic               done,
  output logic [PAYLOAD-1:0] rdata,
  output logic               rdata_valid,
  output logic               SCLK,
  output logic               SSB,
  output logic               MOSI,
  input  logic               MISO
);

  localparam int PCW = (CLKDIV > 1) ? $clog2(CLKDIV) : 1;
  localparam int ECW = $clog2(PKTSZ + 1);

  localparam logic [PCW-1:0] PH_LAST  = PCW'(CLKDIV - 1);
  localparam logic [ECW-1:0] EDGE_ALL = ECW'(PKTSZ);
  localparam logic [ECW-1:0] EDGE_HDR = ECW'(HEADER);

  spi_state_e         state_q, state_d;
  logic [PCW-1:0]     cnt_q, cnt_d;
  logic [ECW-1:0]     edge_q, edge_d;
  logic [PKTSZ-1:0]   shreg_q, shreg_d;
  logic [PAYLOAD-1:0] rx_q, rx_d;
  logic [PAYLOAD-1:0] rdata_q, rdata_d;
  logic               rw_q, rw_d;
  logic               done_q, done_d;
  logic               rvalid_q, rvalid_d;
  logic               busy_q, sclk_q, ssb_q, mosi_q;
  logic               miso_s;
  logic               ph_end;

  sync_2ff u_miso_sync (
    .clk     (clk),
    .reset_n (reset_n),
    .d_i     (MISO),
    .q_o     (miso_s)
  );

  assign ph_end = (cnt_q == PH_LAST);

  always_comb begin
    state_d  = state_q;
    cnt_d    = cnt_q;
    edge_d   = edge_q;
    shreg_d  = shreg_q;
    rx_d     = rx_q;
    rw_d     = rw_q;
    rdata_d  = rdata_q;
    done_d   = 1'b0;
    rvalid_d = 1'b0;

    // One free-running phase counter paces every non-idle state.
    if (state_q != ST_IDLE) begin
      cnt_d = ph_end ? '0 : cnt_q + 1'b1;
    end

    unique case (state_q)
      ST_IDLE: begin
        if (start) begin
          state_d = ST_SETUP;
          shreg_d = {rw, addr, wdata};
          rw_d    = rw;
          cnt_d   = '0;
          edge_d  = '0;
          rx_d    = '0;
        end
      end
      ST_SETUP: begin
        if (ph_end) begin
          state_d = ST_HIGH;
          edge_d  = edge_q + 1'b1;
        end
      end
      ST_HIGH: begin
        if (ph_end) begin
          // Only edges after the header carry slave data.
          if (rw_q && (edge_q > EDGE_HDR)) begin
            rx_d = {rx_q[PAYLOAD-2:0], miso_s};
          end
          if (edge_q < EDGE_ALL) begin
            state_d = ST_LOW;
            // Rotate rather than shift so every register bit stays live;
            // wrapped bits never reach MOSI because the edge count ends first.
            shreg_d = {shreg_q[PKTSZ-2:0], shreg_q[PKTSZ-1]};
          end else begin
            state_d = ST_HOLD;
          end
        end
      end
      ST_LOW: begin
        if (ph_end) begin
          state_d = ST_HIGH;
          edge_d  = edge_q + 1'b1;
        end
      end
      ST_HOLD: begin
        if (ph_end) begin
          state_d = ST_GAP;
          done_d  = 1'b1;
          if (rw_q) begin
            rdata_d  = rx_q;
            rvalid_d = 1'b1;
          end
        end
      end
      ST_GAP: begin
        if (ph_end) begin
          state_d = ST_IDLE;
        end
      end
      default: begin
        state_d = ST_IDLE;
      end
    endcase
  end

  // Pin levels are registered from the next state so they switch on the
  // same edge as the state itself (SSB falls the cycle after acceptance).
  always_ff @(posedge clk or negedge reset_n) begin
    if (!reset_n) begin
      state_q  <= ST_IDLE;
      cnt_q    <= '0;
      edge_q   <= '0;
      shreg_q  <= '0;
      rx_q     <= '0;
      rw_q     <= 1'b0;
      rdata_q  <= '0;
      done_q   <= 1'b0;
      rvalid_q <= 1'b0;
      busy_q   <= 1'b0;
      sclk_q   <= 1'b0;
      ssb_q    <= 1'b1;
      mosi_q   <= 1'b0;
    end else begin
      state_q  <= state_d;
      cnt_q    <= cnt_d;
      edge_q   <= edge_d;
      shreg_q  <= shreg_d;
      rx_q     <= rx_d;
      rw_q     <= rw_d;
      rdata_q  <= rdata_d;
      done_q   <= done_d;
      rvalid_q <= rvalid_d;
      busy_q   <= (state_d != ST_IDLE);
      sclk_q   <= (state_d == ST_HIGH);
      ssb_q    <= ~ssb_active(state_d);
      mosi_q   <= mosi_active(state_d) ? shreg_d[PKTSZ-1] : 1'b0;
    end
  end

  assign busy        = busy_q;
  assign done        = done_q;
  assign rdata       = rdata_q;
  assign rdata_valid = rvalid_q;
  assign SCLK        = sclk_q;
  assign SSB         = ssb_q;
  assign MOSI        = mosi_q;

endmodule

// File: tb/tb_spi_master.sv
// tb/tb_spi_master.sv - directed self-checking bench for spi_master
module tb_spi_master;

  localparam int CLKDIV = 4;

  logic       clk     = 1'b0;
  logic       reset_n = 1'b0;
  logic       start   = 1'b0;
  logic       rw      = 1'b0;
  logic [6:0] addr    = '0;
  logic [7:0] wdata   = '0;
  logic       busy, done, rdata_valid, SCLK, SSB, MOSI;
  logic [7:0] rdata;
  logic       MISO    = 1'b0;

  always #5 clk = ~clk;

  spi_master #(
    .PKTSZ(16), .HEADER(8), .PAYLOAD(8), .ADDRSZ(7), .CLKDIV(CLKDIV)
  ) dut (
    .clk(clk), .reset_n(reset_n), .start(start), .rw(rw), .addr(addr),
    .wdata(wdata), .busy(busy), .done(done), .rdata(rdata),
    .rdata_valid(rdata_valid), .SCLK(SCLK), .SSB(SSB), .MOSI(MOSI), .MISO(MISO)
  );

  int checks = 0;
  int errors = 0;

  // Slave model: captures MOSI on rising SCLK, drives MISO after falling SCLK.
  logic [15:0] s_shift   = '0;
  int          s_rise    = 0;
  logic [7:0]  s_rdval   = '0;
  logic [6:0]  s_reg_addr = '0;
  logic [7:0]  s_rx_d    = '0;
  logic        s_rxdv    = 1'b0;

  always @(negedge SSB) begin
    s_rise  = 0;
    s_shift = '0;
    s_rxdv  = 1'b0;
    MISO    = 1'b0;
  end

  always @(posedge SCLK) begin
    if (!SSB) begin
      s_shift = {s_shift[14:0], MOSI};
      s_rise++;
      if (s_rise == 16 && !s_shift[15]) begin
        s_reg_addr = s_shift[14:8];
        s_rx_d     = s_shift[7:0];
        s_rxdv     = 1'b1;
      end
    end
  end

  always @(negedge SCLK) begin
    if (!SSB && s_rise >= 8 && s_rise < 16) MISO = s_rdval[15 - s_rise];
  end

  // Pin monitor sampled on the falling clk edge.
  int   done_cnt, rv_cnt, falls, run_low, last_low, run_high, min_gap, align_err;
  logic ssb_prev = 1'b1;

  always @(negedge clk) begin
    if (done) begin
      done_cnt++;
      if (!(SSB && !ssb_prev)) align_err++;
    end
    if (rdata_valid) begin
      rv_cnt++;
      if (!done) align_err++;
    end
    if (!SSB) begin
      if (ssb_prev) begin
        falls++;
        if (falls > 1 && run_high < min_gap) min_gap = run_high;
        run_low = 0;
      end
      run_low++;
    end else begin
      if (!ssb_prev) begin
        last_low = run_low;
        run_high = 0;
      end
      run_high++;
    end
    ssb_prev = SSB;
  end

  task automatic clr_mon();
    done_cnt = 0; rv_cnt = 0; falls = 0; run_low = 0; last_low = 0;
    run_high = 0; min_gap = 1000; align_err = 0;
  endtask

  task automatic chk(input string tag, input logic [31:0] got, input logic [31:0] exp);
    checks++;
    assert (got === exp) else begin
      errors++;
      $error("FAIL %s: got 0x%0h expected 0x%0h", tag, got, exp);
    end
  endtask

  task automatic start_txn(input logic r, input logic [6:0] a, input logic [7:0] d);
    @(negedge clk);
    start = 1'b1; rw = r; addr = a; wdata = d;
    @(negedge clk);
    start = 1'b0;
    #1;
  endtask

  task automatic wait_done(input int target, input string tag);
    int n = 0;
    while (done_cnt < target && n < 600) begin
      @(negedge clk); #1; n++;
    end
    checks++;
    assert (done_cnt >= target) else begin
      errors++;
      $error("FAIL %s_timeout: got %0d done pulses expected %0d", tag, done_cnt, target);
    end
    n = 0;
    while (busy && n < 100) begin
      @(negedge clk); #1; n++;
    end
    @(negedge clk); #1;
  endtask

  initial begin
    clr_mon();
    #12;
    chk("rst_ssb",    SSB, 1);
    chk("rst_sclk",   SCLK, 0);
    chk("rst_mosi",   MOSI, 0);
    chk("rst_busy",   busy, 0);
    chk("rst_done",   done, 0);
    chk("rst_rdata",  rdata, 0);
    chk("rst_rvalid", rdata_valid, 0);
    @(negedge clk); reset_n = 1'b1;
    repeat (2) @(negedge clk);
    #1; clr_mon();

    // Write 0x2A <- 0xA5
    start_txn(1'b0, 7'h2A, 8'hA5);
    chk("wr_busy_early", busy, 1);
    chk("wr_ssb_early",  SSB, 0);
    chk("wr_mosi_msb",   MOSI, 0);
    wait_done(1, "wr");
    chk("wr_mosi_word", s_shift, 16'h2AA5);
    chk("wr_ssb_len",   last_low, 132);
    chk("wr_done_cnt",  done_cnt, 1);
    chk("wr_rv_cnt",    rv_cnt, 0);
    chk("wr_rdata",     rdata, 0);
    chk("wr_align",     align_err, 0);

    // Read 0x05, slave returns 0xC3
    clr_mon();
    s_rdval = 8'hC3;
    start_txn(1'b1, 7'h05, 8'h00);
    chk("rd_mosi_msb", MOSI, 1);
    wait_done(1, "rd");
    chk("rd_header",   s_shift[15:8], 8'h85);
    chk("rd_rdata",    rdata, 8'hC3);
    chk("rd_rv_cnt",   rv_cnt, 1);
    chk("rd_done_cnt", done_cnt, 1);
    chk("rd_align",    align_err, 0);
    chk("rd_ssb_len",  last_low, 132);

    // Start pulsed mid-transaction must be ignored
    clr_mon();
    start_txn(1'b0, 7'h10, 8'h3C);
    repeat (40) @(negedge clk);
    start = 1'b1; rw = 1'b1; addr = 7'h55; wdata = 8'hFF;
    @(negedge clk); start = 1'b0; #1;
    wait_done(1, "mid");
    repeat (20) @(negedge clk);
    #1;
    chk("mid_mosi_word", s_shift, 16'h103C);
    chk("mid_falls",     falls, 1);
    chk("mid_done_cnt",  done_cnt, 1);
    chk("mid_rv_cnt",    rv_cnt, 0);
    chk("mid_rdata_kept", rdata, 8'hC3);

    // Start held high: two back-to-back writes
    clr_mon();
    @(negedge clk);
    start = 1'b1; rw = 1'b0; addr = 7'h01; wdata = 8'h02;
    begin
      int n = 0;
      while (done_cnt < 2 && n < 800) begin
        @(negedge clk); #1; n++;
      end
    end
    start = 1'b0;
    wait_done(2, "b2b");
    chk("b2b_done_cnt", done_cnt, 2);
    chk("b2b_falls",    falls, 2);
    chk("b2b_gap_ok",   (min_gap >= CLKDIV) ? 1 : 0, 1);
    chk("b2b_mosi_word", s_shift, 16'h0102);

    // Loopback write 0x11 to 0x7F
    clr_mon();
    start_txn(1'b0, 7'h7F, 8'h11);
    wait_done(1, "lb");
    chk("lb_reg_addr", s_reg_addr, 7'h7F);
    chk("lb_rx_d",     s_rx_d, 8'h11);
    chk("lb_rxdv",     s_rxdv, 1);

    // Reset during the 5th HIGH phase
    clr_mon();
    start_txn(1'b0, 7'h12, 8'h34);
    begin
      int n = 0;
      while (!(s_rise == 5 && SCLK) && n < 200) begin
        @(negedge clk); #1; n++;
      end
      checks++;
      assert (s_rise == 5 && SCLK) else begin
        errors++;
        $error("FAIL rst5_reach: got rise %0d expected 5", s_rise);
      end
    end
    #2 reset_n = 1'b0;
    #1;
    chk("rst5_ssb",   SSB, 1);
    chk("rst5_sclk",  SCLK, 0);
    chk("rst5_mosi",  MOSI, 0);
    chk("rst5_busy",  busy, 0);
    chk("rst5_rdata", rdata, 0);
    repeat (3) @(negedge clk);
    reset_n = 1'b1;
    repeat (3) @(negedge clk);
    #1;
    chk("rst5_no_done", done_cnt, 0);
    clr_mon();
    start_txn(1'b0, 7'h44, 8'h33);
    wait_done(1, "post_rst");
    chk("post_rst_mosi",    s_shift, 16'h4433);
    chk("post_rst_ssb_len", last_low, 132);
    chk("post_rst_done",    done_cnt, 1);

    $display("Simulation finished: %0d checks, %0d errors", checks, errors);
    $finish;
  end

endmodule
